// File: rtl/quad_pkg.sv
// Shared quadrature helpers: Gray mapping of position to {A,B} and step direction.
package quad_pkg;

  typedef enum logic [1:0] {
    Q_00 = 2'b00,
    Q_01 = 2'b01,
    Q_11 = 2'b11,
    Q_10 = 2'b10
  } quad_t;

  function automatic quad_t pos2q(input logic [1:0] p);
    return quad_t'({p[1], p[1] ^ p[0]});
  endfunction

  // Direction from the signed target-pos difference; the half-range tie steps up.
  function automatic logic step_up(input logic diff_msb, input logic diff_low_zero);
    return !diff_msb || diff_low_zero;
  endfunction

endpackage

// File: rtl/quad_emitter_if.sv
// Command/status bundle of quad_emitter. QUAD_EMITTER_INDEX_EN adds index/index_clr.
interface quad_emitter_if #(
  parameter int W        = 16,
  parameter int PERIOD_W = 8
);
  logic [PERIOD_W-1:0] period;
  logic                target_load;
  logic [W-1:0]        target;
  logic [1:0]          q;
  logic [W-1:0]        pos;
  logic                busy;
  logic                done;
`ifdef QUAD_EMITTER_INDEX_EN
  logic                index;
  logic                index_clr;

  modport master (output period, target_load, target, index_clr,
                  input  q, pos, busy, done, index);
  modport slave  (input  period, target_load, target, index_clr,
                  output q, pos, busy, done, index);
`else
  modport master (output period, target_load, target,
                  input  q, pos, busy, done);
  modport slave  (input  period, target_load, target,
                  output q, pos, busy, done);
`endif
endinterface

// File: rtl/quad_emitter_timer.sv
// Step-spacing down-counter: reloads with max(period,1)-1 on a step, flags zero.
module quad_emitter_timer #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] period,
  input  logic                reload,
  input  logic                clr,
  output logic                zero
);
  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] eff_period;

  always_comb begin
    eff_period = (period == '0) ? ONE : period;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (clr) begin
      timer <= '0;
    end else if (timer != '0) begin
      timer <= timer - ONE;
    end else if (reload) begin
      timer <= eff_period - ONE;
    end
  end

  assign zero = (timer == '0);

endmodule

// File: rtl/quad_emitter.sv
// Quadrature encoder emitter: walks pos toward a loaded target, one state per step.
// Optional QUAD_EMITTER_INDEX_EN adds an index output and synchronous index_clr.
module quad_emitter
  import quad_pkg::*;
#(
  parameter int W        = 16,
  parameter int PERIOD_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  quad_emitter_if.slave bus
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] target_r;
  logic [W-1:0] pos_r;
  logic [W-1:0] diff;
  logic [W-1:0] pos_next;
  quad_t        q_r;
  logic         done_r;
  logic         zero;
  logic         step;
  logic         clr;

`ifdef QUAD_EMITTER_INDEX_EN
  logic index_r;
  assign clr       = bus.index_clr;
  assign bus.index = index_r;
`else
  assign clr = 1'b0;
`endif

  always_comb begin
    diff     = target_r - pos_r;
    step     = zero && (pos_r != target_r) && !clr;
    pos_next = step_up(diff[W-1], diff[W-2:0] == '0) ? pos_r + ONE : pos_r - ONE;
  end

  quad_emitter_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .period (bus.period),
    .reload (step),
    .clr    (clr),
    .zero   (zero)
  );

  // A step compares against the target_r held before any same-cycle load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_r <= '0;
      pos_r    <= '0;
      q_r      <= Q_00;
      done_r   <= 1'b0;
    end else begin
      if (bus.target_load) begin
        target_r <= bus.target;
      end
      if (clr) begin
        pos_r  <= '0;
        q_r    <= Q_00;
        done_r <= 1'b0;
      end else if (step) begin
        pos_r  <= pos_next;
        q_r    <= pos2q(pos_next[1:0]);
        done_r <= (pos_next == target_r);
      end else begin
        done_r <= 1'b0;
      end
    end
  end

`ifdef QUAD_EMITTER_INDEX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_r <= 1'b0;
    end else if (clr) begin
      index_r <= 1'b1;
    end else if (step) begin
      index_r <= (pos_next == '0);
    end
  end
`endif

  assign bus.q    = q_r;
  assign bus.pos  = pos_r;
  assign bus.busy = (pos_r != target_r);
  assign bus.done = done_r;

endmodule

// File: tb/tb_quad_emitter.sv
// Bench for quad_emitter: directed loads against a time-based behavioural model.
module tb_quad_emitter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  quad_emitter_if #(.W(16), .PERIOD_W(8)) bus ();

  quad_emitter #(.W(16), .PERIOD_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position moves when away from target and the cycle number has reached
  // the earliest allowed step time; a step pushes that time eff_period cycles out.
  logic [1:0]  gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int unsigned cyc;
  int unsigned m_ready;
  logic [15:0] m_pos, m_tgt;
  logic        m_done, m_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_ready = 0; m_pos = '0; m_tgt = '0; m_done = 1'b0; m_idx = 1'b0;
    end else begin
      logic [15:0] old_tgt;
      int d;
      logic clr_now;
      cyc++;
      m_done  = 1'b0;
      old_tgt = m_tgt;
      clr_now = 1'b0;
`ifdef QUAD_EMITTER_INDEX_EN
      clr_now = bus.index_clr;
`endif
      if (clr_now) begin
        m_pos = '0; m_ready = cyc + 1; m_idx = 1'b1;
      end else if (m_pos != m_tgt && cyc >= m_ready) begin
        d = int'(m_tgt) - int'(m_pos);
        if (d > 32768) d -= 65536;
        if (d <= -32768) d += 65536;
        m_pos   = (d > 0) ? m_pos + 16'd1 : m_pos - 16'd1;
        m_ready = cyc + ((bus.period == 8'd0) ? 1 : int'(bus.period));
        m_done  = (m_pos == old_tgt);
        m_idx   = (m_pos == 16'd0);
      end
      if (bus.target_load) m_tgt = bus.target;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("pos", 32'(bus.pos), 32'(m_pos));
      chk("q", 32'(bus.q), 32'(gray[m_pos[1:0]]));
      chk("busy", 32'(bus.busy), 32'(m_pos != m_tgt));
      chk("done", 32'(bus.done), 32'(m_done));
`ifdef QUAD_EMITTER_INDEX_EN
      chk("index", 32'(bus.index), 32'(m_idx));
`endif
      if (bus.done) done_cnt++;
    end
  end

  task automatic load(input logic [15:0] v);
    @(posedge clk); #1;
    bus.target_load = 1'b1;
    bus.target      = v;
    @(posedge clk); #1;
    bus.target_load = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.done) break;
    end
    chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    done_cnt = 0;
  endtask

  initial begin
    bus.period = 8'd0;
    bus.target_load = 1'b0;
    bus.target = '0;
`ifdef QUAD_EMITTER_INDEX_EN
    bus.index_clr = 1'b0;
`endif
    #3;
    chk("rst_pos", 32'(bus.pos), 32'd0);
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Forward move, period 3
    done_cnt = 0;
    bus.period = 8'd3;
    load(16'd5);
    @(posedge clk); #1;
    chk("t1_first_step", 32'(bus.pos), 32'd1);
    chk("t1_first_q", 32'(bus.q), 32'b01);
    wait_idle(100);
    chk("t1_pos", 32'(bus.pos), 32'd5);
    chk("t1_q", 32'(bus.q), 32'b01);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);

    // Wrap downward, period 1
    do_reset();
    bus.period = 8'd1;
    load(16'hFFFE);
    @(posedge clk); #1;
    chk("t2_pos_a", 32'(bus.pos), 32'hFFFF);
    chk("t2_q_a", 32'(bus.q), 32'b10);
    @(posedge clk); #1;
    chk("t2_pos_b", 32'(bus.pos), 32'hFFFE);
    chk("t2_q_b", 32'(bus.q), 32'b11);
    wait_idle(10);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);

    // Half-range tie steps up; then asynchronous reset mid-move
    do_reset();
    bus.period = 8'd1;
    load(16'h8000);
    @(posedge clk); #1;
    chk("t3_tie", 32'(bus.pos), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t3_rst_pos", 32'(bus.pos), 32'd0);
    chk("t3_rst_q", 32'(bus.q), 32'd0);
    chk("t3_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("t3_no_step", 32'(bus.pos), 32'd0);

    // Mid-move retarget keeps spacing
    done_cnt = 0;
    bus.period = 8'd4;
    load(16'd10);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.pos == 16'd4) break;
    end
    chk("t4_reach4", 32'(bus.pos), 32'd4);
    load(16'd2);
    wait_idle(200);
    chk("t4_pos", 32'(bus.pos), 32'd2);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);

    // period 0 behaves as 1; loading the current position is silent
    do_reset();
    bus.period = 8'd0;
    load(16'd3);
    repeat (3) @(posedge clk); #1;
    chk("t5_pos", 32'(bus.pos), 32'd3);
    wait_idle(10);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    done_cnt = 0;
    load(16'd3);
    repeat (5) @(posedge clk); #1;
    chk("t5_same_busy", 32'(bus.busy), 32'd0);
    chk("t5_same_done", 32'(done_cnt), 32'd0);

`ifdef QUAD_EMITTER_INDEX_EN
    // index_clr forces pos to 0 and the emitter walks back to 3
    bus.period = 8'd1;
    @(posedge clk); #1;
    bus.index_clr = 1'b1;
    @(posedge clk); #1;
    bus.index_clr = 1'b0;
    chk("t6_clr_pos", 32'(bus.pos), 32'd0);
    chk("t6_index", 32'(bus.index), 32'd1);
    wait_idle(20);
    chk("t6_pos", 32'(bus.pos), 32'd3);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
